// File: rtl/mram_bus_sequencer_if.sv
// mram_bus_sequencer_if: request/response handshake plus MRAM pin bundle
interface mram_bus_sequencer_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mram_addr;
  logic [DATA_W-1:0] mram_dq_o;
  logic              mram_dq_oe;
  logic [DATA_W-1:0] mram_dq_i;
  logic              mram_ce_n;
  logic              mram_we_n;
  logic              mram_oe_n;
  logic              mram_lb_n;
  logic              mram_ub_n;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, mram_dq_i,
    input  req_ready, rsp_valid, rsp_rdata, mram_addr, mram_dq_o, mram_dq_oe,
           mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, mram_dq_i,
    output req_ready, rsp_valid, rsp_rdata, mram_addr, mram_dq_o, mram_dq_oe,
           mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n
  );
endinterface

// File: rtl/mram_bus_sequencer.sv
// mram_bus_sequencer: runs one MRAM read/write with programmable setup, pulse, access and recovery
module mram_bus_sequencer #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 1,
  parameter int T_WP    = 3,
  parameter int T_ACC   = 4,
  parameter int T_REC   = 1
) (
  input logic clk,
  input logic rst,
  mram_bus_sequencer_if.slave bus
);
  localparam int M1 = T_SETUP > T_WP ? T_SETUP : T_WP;
  localparam int M2 = T_ACC > T_REC ? T_ACC : T_REC;
  localparam int T_MAX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(T_MAX) + 1;
  localparam int H = DATA_W / 2;
  typedef enum logic [2:0] {IDLE, SETUP, WPULSE, RACCESS, RECOVER} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, ld;
  logic wr_q, accept, done, wr, act;
  logic [1:0] be_q, be;
  logic ce_d, we_d, oe_d, lb_d, ub_d, dq_oe_d, rsp_d;
  assign accept = state == IDLE && bus.req_valid;
  assign done = cnt == '0;
  assign bus.req_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? ld : done ? cnt : cnt - CW'(1);
    end
  always_comb begin
    nxt = state == IDLE ? (bus.req_valid ? SETUP : IDLE) :
          !done ? state :
          state == SETUP ? (wr_q ? WPULSE : RACCESS) :
          state == RECOVER ? IDLE : RECOVER;
    ld = nxt == SETUP ? CW'(T_SETUP - 1) :
         nxt == WPULSE ? CW'(T_WP - 1) :
         nxt == RACCESS ? CW'(T_ACC - 1) :
         nxt == RECOVER ? CW'(T_REC - 1) : '0;
  end
  // Pin values are computed for the state being entered so every strobe leaves a flop.
  always_comb begin
    wr = accept ? bus.req_write : wr_q;
    be = accept ? bus.req_be : be_q;
    act = nxt == SETUP || nxt == WPULSE || nxt == RACCESS;
    ce_d = !act;
    lb_d = !(act && be[0]);
    ub_d = !(act && be[1]);
    we_d = nxt != WPULSE;
    oe_d = nxt != RACCESS;
    dq_oe_d = wr && nxt != IDLE && nxt != RACCESS;
    rsp_d = state == RACCESS && done;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= 1'b0;
      be_q <= 2'b00;
      bus.mram_addr <= '0;
      bus.mram_dq_o <= '0;
      bus.mram_dq_oe <= 1'b0;
      bus.mram_ce_n <= 1'b1;
      bus.mram_we_n <= 1'b1;
      bus.mram_oe_n <= 1'b1;
      bus.mram_lb_n <= 1'b1;
      bus.mram_ub_n <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      if (accept) begin
        wr_q <= bus.req_write;
        be_q <= bus.req_be;
        bus.mram_addr <= bus.req_addr;
        bus.mram_dq_o <= bus.req_wdata;
      end
      bus.mram_dq_oe <= dq_oe_d;
      bus.mram_ce_n <= ce_d;
      bus.mram_we_n <= we_d;
      bus.mram_oe_n <= oe_d;
      bus.mram_lb_n <= lb_d;
      bus.mram_ub_n <= ub_d;
      bus.rsp_valid <= rsp_d;
      if (rsp_d)
        bus.rsp_rdata <= {be_q[1] ? bus.mram_dq_i[DATA_W-1:H] : H'(0),
                          be_q[0] ? bus.mram_dq_i[H-1:0] : H'(0)};
    end
endmodule

// File: tb/tb_mram_bus_sequencer.sv
// tb_mram_bus_sequencer: scoreboard bench for default and overridden timing instances
module tb_mram_bus_sequencer;
  typedef struct {logic [15:0] d; int t;} rsp_t;
  localparam int TS [2] = '{1, 2};
  localparam int TW [2] = '{3, 1};
  localparam int TA [2] = '{4, 6};
  localparam int TR [2] = '{1, 3};
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] v = 2'b00;
  logic r_write = 1'b0;
  logic [19:0] r_addr = '0;
  logic [15:0] r_wdata = '0, r_exp = '0, dq_model = '0;
  logic [1:0] r_be = 2'b00;
  int cyc = 0, total = 0, bad = 0;
  int e0 [2] = '{-1000, -1000};
  logic ew [2] = '{1'b0, 1'b0};
  logic [1:0] eb [2] = '{2'b00, 2'b00};
  logic [19:0] ea [2] = '{20'h0, 20'h0};
  logic [15:0] ed [2] = '{16'h0, 16'h0};
  rsp_t sb [2][$];
  logic [6:0] pins [2];
  logic [19:0] maddr [2];
  logic [15:0] mdq [2], rdat [2];
  logic rv [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mram_bus_sequencer_if #(.ADDR_W(20), .DATA_W(16)) ia ();
  mram_bus_sequencer_if #(.ADDR_W(20), .DATA_W(16)) ib ();
  assign ia.req_valid = v[0];
  assign ib.req_valid = v[1];
  assign ia.req_write = r_write;
  assign ib.req_write = r_write;
  assign ia.req_addr = r_addr;
  assign ib.req_addr = r_addr;
  assign ia.req_wdata = r_wdata;
  assign ib.req_wdata = r_wdata;
  assign ia.req_be = r_be;
  assign ib.req_be = r_be;
  assign ia.mram_dq_i = dq_model;
  assign ib.mram_dq_i = dq_model;
  mram_bus_sequencer dut_a (.clk(clk), .rst(rst), .bus(ia));
  mram_bus_sequencer #(.T_SETUP(2), .T_WP(1), .T_ACC(6), .T_REC(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  // pin vector: {ready, ce_n, we_n, oe_n, lb_n, ub_n, dq_oe}
  assign pins[0] = {ia.req_ready, ia.mram_ce_n, ia.mram_we_n, ia.mram_oe_n, ia.mram_lb_n, ia.mram_ub_n, ia.mram_dq_oe};
  assign pins[1] = {ib.req_ready, ib.mram_ce_n, ib.mram_we_n, ib.mram_oe_n, ib.mram_lb_n, ib.mram_ub_n, ib.mram_dq_oe};
  assign maddr[0] = ia.mram_addr;
  assign maddr[1] = ib.mram_addr;
  assign mdq[0] = ia.mram_dq_o;
  assign mdq[1] = ib.mram_dq_o;
  assign rdat[0] = ia.rsp_rdata;
  assign rdat[1] = ib.rsp_rdata;
  assign rv[0] = ia.rsp_valid;
  assign rv[1] = ib.rsp_valid;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // d = cycles since the accept edge; pins follow from the programmed intervals
  function automatic logic [6:0] exp_pins(int d, int k, logic w, logic [1:0] be);
    int tot;
    logic a;
    tot = w ? TS[k] + TW[k] + TR[k] : TS[k] + TA[k] + TR[k];
    a = d < (w ? TS[k] + TW[k] : TS[k] + TA[k]);
    return {d >= tot, !a, !(w && d >= TS[k] && d < TS[k] + TW[k]),
            !(!w && d >= TS[k] && d < TS[k] + TA[k]), !(a && be[0]), !(a && be[1]), w && d < tot};
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int d;
      logic [6:0] ep;
      rsp_t e;
      if (rst) begin
        e0[k] = -1000;
        sb[k].delete();
      end
      d = cyc - e0[k];
      ep = exp_pins(d, k, ew[k], eb[k]);
      chk($sformatf("pins%0d", k), 32'(pins[k]), 32'(ep));
      if (!ep[5]) chk($sformatf("addr%0d", k), 32'(maddr[k]), 32'(ea[k]));
      if (ep[0]) chk($sformatf("dq_o%0d", k), 32'(mdq[k]), 32'(ed[k]));
      chk($sformatf("overlap%0d", k), 32'({!pins[k][4] && !pins[k][3], pins[k][0] && !pins[k][3]}), 32'(0));
      if (rv[k]) begin
        if (sb[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected%0d: got rsp_valid=1 want 0 (cycle %0d)", k, cyc);
        end else begin
          e = sb[k].pop_front();
          chk($sformatf("rsp_time%0d", k), 32'(cyc), 32'(e.t));
          chk($sformatf("rsp_data%0d", k), 32'(rdat[k]), 32'(e.d));
        end
      end else if (sb[k].size() != 0 && sb[k][0].t < cyc) begin
        e = sb[k].pop_front();
        total++;
        bad++;
        $display("FAIL rsp_missing%0d: got rsp_valid=0 want 1 at cycle %0d", k, e.t);
      end
      if (!rst && v[k] && pins[k][6]) begin
        e0[k] = cyc + 1;
        ew[k] = r_write;
        eb[k] = r_be;
        ea[k] = r_addr;
        ed[k] = r_wdata;
        if (!r_write) sb[k].push_back(rsp_t'{r_exp, cyc + 1 + TS[k] + TA[k]});
      end
    end
  end
  task automatic issue(input int k, input logic w, input logic [19:0] ad, input logic [15:0] wd,
                       input logic [1:0] be, input logic [15:0] ex, input bit hold, output int acc);
    int n;
    r_write = w;
    r_addr = ad;
    r_wdata = wd;
    r_be = be;
    r_exp = ex;
    v[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pins[k][6] && n < 50);
    acc = cyc + 1;
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout%0d: got no ready want ready within 50 cycles", k);
    end
    @(posedge clk);
    #1;
    if (!hold) v[k] = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int a0, a1, a2, a3;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pins", 32'(pins[k]), 32'h7E);
      chk("rst_rsp", 32'({rv[k], rdat[k]}), 32'(0));
      chk("rst_addr_dq", 32'({maddr[k][15:0], mdq[k]}), 32'(0));
    end
    r_write = 1'b1;
    v = 2'b11;
    repeat (3) @(posedge clk);
    #1 v = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    issue(0, 1'b1, 20'h0ABCD, 16'h1234, 2'b11, 16'h0, 1'b0, a0);
    idle(8);
    dq_model = 16'hBEEF;
    issue(0, 1'b0, 20'h00010, 16'h0, 2'b11, 16'hBEEF, 1'b0, a0);
    idle(16);
    chk("rdata_hold", 32'(ia.rsp_rdata), 32'h0000BEEF);
    issue(0, 1'b0, 20'h00011, 16'h0, 2'b10, 16'hBE00, 1'b0, a0);
    idle(8);
    issue(0, 1'b1, 20'h00FFF, 16'hA5A5, 2'b00, 16'h0, 1'b0, a0);
    idle(8);
    issue(0, 1'b1, 20'h00100, 16'h1111, 2'b11, 16'h0, 1'b1, a0);
    issue(0, 1'b1, 20'h00101, 16'h2222, 2'b01, 16'h0, 1'b1, a1);
    issue(0, 1'b1, 20'h00102, 16'h3333, 2'b10, 16'h0, 1'b1, a2);
    dq_model = 16'h5A5A;
    issue(0, 1'b0, 20'h12345, 16'h0, 2'b01, 16'h005A, 1'b0, a3);
    chk("gap_w1_w2", 32'(a1 - a0), 32'd6);
    chk("gap_w2_w3", 32'(a2 - a1), 32'd6);
    chk("gap_w3_rd", 32'(a3 - a2), 32'd6);
    idle(10);
    issue(0, 1'b1, 20'h00F00, 16'hCAFE, 2'b11, 16'h0, 1'b0, a0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_pins", 32'(pins[0]), 32'h7E);
    chk("midrst_rsp", 32'(rv[0]), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    dq_model = 16'h1357;
    issue(0, 1'b0, 20'h00020, 16'h0, 2'b11, 16'h1357, 1'b0, a0);
    idle(10);
    issue(1, 1'b1, 20'h0BEEF, 16'h0F0F, 2'b11, 16'h0, 1'b1, a0);
    issue(1, 1'b1, 20'h0BEF0, 16'hF0F0, 2'b11, 16'h0, 1'b0, a1);
    chk("gap_b_w", 32'(a1 - a0), 32'd7);
    idle(10);
    dq_model = 16'hC0DE;
    issue(1, 1'b0, 20'h00100, 16'h0, 2'b01, 16'h00DE, 1'b0, a0);
    idle(14);
    for (int k = 0; k < 2; k++) chk("sb_empty", 32'(sb[k].size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
